apb_slave_regbank: RTL and testbench



---
 rtl/apb_slave_regbank.sv | 179 +++++++++++++++++
 tb/tb_apb_slave_regbank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// APB completer: byte-strobed register bank with a fixed wait-state count and error response.
// Optional build macro APB_SLAVE_PROT_CHECK_EN makes the upper half of the bank privileged-only.
module apb_slave_regbank #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           pprot,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LB     = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << LB) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [3:0]              cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    write_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [STRB_W-1:0]       strb_r;
    logic                    prot_r;
    logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];

    logic                    pready_r;
    logic [DATA_WIDTH-1:0]   prdata_r;
    logic                    pslverr_r;

    logic                    setup_s;
    logic                    access_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic                    write_s;
    logic                    prot_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    misalign_s;
    logic                    range_s;
    logic                    prot_err_s;
    logic                    err_s;
    logic                    do_write_s;

    assign setup_s  = psel & ~penable;
    assign access_s = psel & penable;

    // In IDLE the transfer attributes come straight off the bus so a zero-wait
    // transfer can present its response on the first access cycle.
    assign addr_s  = (state_r == ST_IDLE) ? paddr  : addr_r;
    assign write_s = (state_r == ST_IDLE) ? pwrite : write_r;
    assign prot_s  = (state_r == ST_IDLE) ? pprot  : prot_r;

    assign idx_s      = addr_s[LB +: IDX_W];
    assign misalign_s = ((addr_s & LANE_MASK) != '0);
    assign range_s    = ((addr_s >> (LB + IDX_W)) != '0);
`ifdef APB_SLAVE_PROT_CHECK_EN
    assign prot_err_s = ~prot_s & idx_s[IDX_W-1];
`else
    // pprot is captured but carries no access rule in this build
    assign prot_err_s = 1'b0 & ~prot_s;
`endif
    assign err_s      = misalign_s | range_s | prot_err_s;
    assign do_write_s = (state_r == ST_DONE) & access_s & write_r & ~err_s;

    // Next-state logic; dropping psel aborts from any state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (setup_s) begin
                    next_state_s = (WAIT_INIT != 4'd0) ? ST_WAIT : ST_DONE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    next_state_s = ST_IDLE;
                end else if (penable && (cnt_r == 4'd1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (!psel || penable) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register, wait counter and captured setup-phase attributes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            write_r <= 1'b0;
            wdata_r <= '0;
            strb_r  <= '0;
            prot_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && setup_s) begin
                cnt_r   <= WAIT_INIT;
                addr_r  <= paddr;
                write_r <= pwrite;
                wdata_r <= pwdata;
                strb_r  <= pstrb;
                prot_r  <= pprot;
            end else if ((state_r == ST_WAIT) && access_s) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Registered response, aligned with entry into DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pready_r  <= 1'b0;
            prdata_r  <= '0;
            pslverr_r <= 1'b0;
        end else begin
            pready_r  <= (next_state_s == ST_DONE);
            pslverr_r <= (next_state_s == ST_DONE) & err_s;
            if ((next_state_s == ST_DONE) && !write_s && !err_s) begin
                prdata_r <= regs_r[idx_s];
            end else begin
                prdata_r <= '0;
            end
        end
    end

    // Register bank with per-lane write enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (do_write_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_r[b]) begin
                    regs_r[idx_s][b*8 +: 8] <= wdata_r[b*8 +: 8];
                end
            end
        end
    end

    assign pready  = pready_r;
    assign prdata  = prdata_r;
    assign pslverr = pslverr_r;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: a zero-wait instance and a three-wait instance share one APB bus.
module tb_apb_slave_regbank;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  paddr;
    logic         pprot, psel0, psel3, penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [31:0]  prdata0, prdata3;
    logic [511:0] reg_out0, reg_out3;

    logic [31:0]  m0 [16];
    logic [31:0]  m3 [16];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    apb_slave_regbank #(.WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .paddr(paddr), .pprot(pprot), .psel(psel0),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready0), .prdata(prdata0), .pslverr(pslverr0), .reg_out(reg_out0)
    );

    apb_slave_regbank #(.WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .paddr(paddr), .pprot(pprot), .psel(psel3),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready3), .prdata(prdata3), .pslverr(pslverr3), .reg_out(reg_out3)
    );

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        pr;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic model_err(input logic [15:0] a, input logic pr);
        logic e;
        e = (a[1:0] != 2'd0) || (a[15:6] != 10'd0);
`ifdef APB_SLAVE_PROT_CHECK_EN
        if (a[5] && !pr) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic model_write(input bit w3, input logic [15:0] a, input logic [31:0] wd,
                               input logic [3:0] st, input logic pr);
        logic [31:0] v;
        if (!model_err(a, pr)) begin
            v = w3 ? m3[a[5:2]] : m0[a[5:2]];
            for (int b = 0; b < 4; b++) if (st[b]) v[b*8 +: 8] = wd[b*8 +: 8];
            if (w3) m3[a[5:2]] = v; else m0[a[5:2]] = v;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m0[i] = 32'd0;
            m3[i] = 32'd0;
        end
    endtask

    task automatic check_bank(input bit w3, input string name);
        for (int i = 0; i < 16; i++) begin
            if (w3) check32(name, reg_out3[i*32 +: 32], m3[i]);
            else    check32(name, reg_out0[i*32 +: 32], m0[i]);
        end
    endtask

    // Called at a negedge; returns at the negedge after the completing edge.
    task automatic xfer(input bit w3, input logic [15:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic pr,
                        output logic [31:0] rd, output logic err, output int waits);
        logic rdy;
        psel0 = !w3; psel3 = w3; penable = 1'b0;
        paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        rdy = w3 ? pready3 : pready0;
        while (!rdy && waits < 40) begin
            @(negedge clk);
            waits++;
            rdy = w3 ? pready3 : pready0;
        end
        rd  = w3 ? prdata3 : prdata0;
        err = w3 ? pslverr3 : pslverr0;
        if (!rdy) begin
            n_checks++;
            $display("FAIL timeout: pready not seen after %0d cycles", waits);
        end
        @(negedge clk);
        if (wr) model_write(w3, a, wd, st, pr);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    vec_t        vecs [13];
    logic [31:0] rd;
    logic        err;
    int          waits;
    logic        exp_perr;

    initial begin
        vecs[0]  = '{16'h0004, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b0};
        vecs[1]  = '{16'h0004, 1'b0, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{16'h0000, 1'b1, 32'hAABBCCDD, 4'hF, 1'b1, 32'h0,        1'b0};
        vecs[3]  = '{16'h0000, 1'b1, 32'h11223344, 4'h5, 1'b1, 32'h0,        1'b0};
        vecs[4]  = '{16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 32'hAA22CC44, 1'b0};
        vecs[5]  = '{16'h0002, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        1'b1};
        vecs[6]  = '{16'h0002, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        vecs[7]  = '{16'h0040, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        1'b1};
        vecs[8]  = '{16'h0040, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        vecs[9]  = '{16'h0000, 1'b0, 32'h0,        4'h0, 1'b1, 32'hAA22CC44, 1'b0};
        vecs[10] = '{16'h003C, 1'b1, 32'h0BADF00D, 4'hC, 1'b1, 32'h0,        1'b0};
        vecs[11] = '{16'h003C, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0BAD0000, 1'b0};
        vecs[12] = '{16'h0008, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0};

        model_clear();
        reset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 16'd0; pwdata = 32'd0; pstrb = 4'd0; pprot = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check32("reset_pready0",  {31'd0, pready0},  32'd0);
        check32("reset_prdata0",  prdata0,           32'd0);
        check32("reset_pslverr0", {31'd0, pslverr0}, 32'd0);
        check32("reset_pready3",  {31'd0, pready3},  32'd0);
        check_bank(1'b0, "reset_bank0");

        // Table vectors on the zero-wait instance, issued back to back.
        for (int i = 0; i < 13; i++) begin
            xfer(1'b0, vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].st, vecs[i].pr, rd, err, waits);
            check32($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check32($sformatf("vec%0d_waits", i), waits, 32'd0);
            if (!vecs[i].wr) check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check32($sformatf("vec%0d_regout1", i), reg_out0[63:32], m0[1]);
        end
        check_bank(1'b0, "table_bank0");

        // penable high without a setup phase is ignored.
        psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0000;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(negedge clk);
        check32("noset_pready", {31'd0, pready0}, 32'd0);
        @(negedge clk);
        check32("noset_pready2", {31'd0, pready0}, 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk);
        check32("noset_reg0", reg_out0[31:0], 32'hAA22CC44);

        // Privilege check on the upper half of the bank.
`ifdef APB_SLAVE_PROT_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        xfer(1'b0, 16'h0020, 1'b1, 32'h12345678, 4'hF, 1'b0, rd, err, waits);
        check32("prot0_err", {31'd0, err}, {31'd0, exp_perr});
        check32("prot0_reg8", reg_out0[8*32 +: 32], exp_perr ? 32'd0 : 32'h12345678);
        xfer(1'b0, 16'h0020, 1'b0, 32'h0, 4'h0, 1'b0, rd, err, waits);
        check32("prot0_rd_err", {31'd0, err}, {31'd0, exp_perr});
        check32("prot0_rd", rd, exp_perr ? 32'd0 : 32'h12345678);
        xfer(1'b0, 16'h0020, 1'b1, 32'h12345678, 4'hF, 1'b1, rd, err, waits);
        check32("prot1_err", {31'd0, err}, 32'd0);
        xfer(1'b0, 16'h0020, 1'b0, 32'h0, 4'h0, 1'b1, rd, err, waits);
        check32("prot1_rd", rd, 32'h12345678);
        check_bank(1'b0, "prot_bank0");

        // Three wait states: pready low for exactly three access cycles.
        xfer(1'b1, 16'h0004, 1'b0, 32'h0, 4'h0, 1'b1, rd, err, waits);
        check32("ws3_read_waits", waits, 32'd3);
        check32("ws3_read_data", rd, 32'd0);
        xfer(1'b1, 16'h0040, 1'b0, 32'h0, 4'h0, 1'b1, rd, err, waits);
        check32("ws3_illegal_waits", waits, 32'd3);
        check32("ws3_illegal_err", {31'd0, err}, 32'd1);

        // Abort during WAIT on a write to 0x0008.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008;
        pwdata = 32'h00000055; pstrb = 4'hF; pprot = 1'b1;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check32("abort_wait_pready", {31'd0, pready3}, 32'd0);
        psel3 = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check32("abort_pready", {31'd0, pready3}, 32'd0);
        end
        check32("abort_reg2", reg_out3[2*32 +: 32], 32'd0);
        xfer(1'b1, 16'h0008, 1'b1, 32'h00000077, 4'hF, 1'b1, rd, err, waits);
        check32("after_abort_waits", waits, 32'd3);
        xfer(1'b1, 16'h0008, 1'b0, 32'h0, 4'h0, 1'b1, rd, err, waits);
        check32("after_abort_rd", rd, 32'h00000077);
        check_bank(1'b1, "abort_bank3");

        // Reset while the response is being presented clears outputs at once.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0008;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        while (!pready3 && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        check32("rst_pre_rd", prdata3, 32'h00000077);
        reset = 1'b1;
        #1;
        check32("rst_pready", {31'd0, pready3}, 32'd0);
        check32("rst_prdata", prdata3, 32'd0);
        check32("rst_pslverr", {31'd0, pslverr3}, 32'd0);
        model_clear();
        check_bank(1'b1, "rst_bank3");
        @(negedge clk);
        reset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        @(negedge clk);

        // Reset during WAIT discards the pending write.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C;
        pwdata = 32'h00000099; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check32("rstwait_pready", {31'd0, pready3}, 32'd0);
        @(negedge clk);
        reset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        repeat (4) @(negedge clk);
        check32("rstwait_reg3", reg_out3[3*32 +: 32], 32'd0);
        xfer(1'b1, 16'h000C, 1'b1, 32'h00000099, 4'hF, 1'b1, rd, err, waits);
        xfer(1'b1, 16'h000C, 1'b0, 32'h0, 4'h0, 1'b1, rd, err, waits);
        check32("rstwait_rd", rd, 32'h00000099);
        check32("rstwait_err", {31'd0, err}, 32'd0);
        check_bank(1'b1, "final_bank3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
